ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 34 +++
 rtl/ultrasonic_ranger.sv | 208 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ============================================================================
// Module : ultrasonic_pkg
// Brief  : Shared FSM state type, 50 MHz default timing and width helper for
//          the ultrasonic ranger.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    localparam int c_def_n_ch           = 2;
    localparam int c_def_trig_cycles    = 500;        // 10 us
    localparam int c_def_period_cycles  = 3_000_000;  // 60 ms
    localparam int c_def_timeout_cycles = 1_500_000;  // 30 ms
    localparam int c_def_cm_div         = 2900;
    localparam int c_def_dist_w         = 9;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchroniser for a bus of independent asynchronous bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
// ============================================================================
// Module : ultrasonic_ranger
// Brief  : Round-robin trigger/echo ranger for HC-SR04 style sensors; one FSM
//          and one counter set shared by all channels.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int N_CH           = c_def_n_ch,
    parameter int TRIG_CYCLES    = c_def_trig_cycles,
    parameter int PERIOD_CYCLES  = c_def_period_cycles,
    parameter int TIMEOUT_CYCLES = c_def_timeout_cycles,
    parameter int CM_DIV         = c_def_cm_div,
    parameter int DIST_W         = c_def_dist_w
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [N_CH-1:0]             echo,
    output logic [N_CH-1:0]             trigger,
    output logic [DIST_W-1:0]           dist_cm,
    output logic [width_of(N_CH)-1:0]   dist_ch,
    output logic                        dist_valid,
    output logic                        timeout
);

    localparam int c_chw  = width_of(N_CH);
    localparam int c_tcw  = width_of(TRIG_CYCLES);
    localparam int c_pw   = width_of(PERIOD_CYCLES);
    localparam int c_tw   = width_of(TIMEOUT_CYCLES);
    localparam int c_sw   = width_of(CM_DIV);

    localparam logic [c_chw-1:0]  c_ch_last     = c_chw'(N_CH - 1);
    localparam logic [c_tcw-1:0]  c_trig_last   = c_tcw'(TRIG_CYCLES - 1);
    localparam logic [c_pw-1:0]   c_period_last = c_pw'(PERIOD_CYCLES - 1);
    localparam logic [c_tw-1:0]   c_to_last     = c_tw'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tw-1:0]   c_to_first    = c_tw'((TIMEOUT_CYCLES > 1) ? 1 : 0);
    localparam logic [c_sw-1:0]   c_sub_last    = c_sw'(CM_DIV - 1);
    localparam logic [DIST_W-1:0] c_cm_max      = {DIST_W{1'b1}};

    state_t             state_q,      state_d;
    logic [c_chw-1:0]   ch_q,         ch_d;
    logic [c_tcw-1:0]   trig_cnt_q,   trig_cnt_d;
    logic [c_pw-1:0]    period_cnt_q, period_cnt_d;
    logic [c_tw-1:0]    wait_cnt_q,   wait_cnt_d;
    logic [c_sw-1:0]    sub_cnt_q,    sub_cnt_d;
    logic [DIST_W-1:0]  cm_cnt_q,     cm_cnt_d;
    logic [N_CH-1:0]    trigger_q,    trigger_d;
    logic [DIST_W-1:0]  dist_cm_q,    dist_cm_d;
    logic [c_chw-1:0]   dist_ch_q,    dist_ch_d;
    logic               dist_valid_q, dist_valid_d;
    logic               timeout_q,    timeout_d;

    logic [N_CH-1:0]    w_echo_s;
    logic               w_echo;
    logic [c_sw-1:0]    w_sub_base,   w_sub_next;
    logic [DIST_W-1:0]  w_cm_base,    w_cm_next;
    logic               w_done;
    logic               w_fail;

    sync_2ff #(
        .WIDTH (N_CH)
    ) u_echo_sync (
        .clk (clk),
        .rst (rst),
        .d   (echo),
        .q   (w_echo_s)
    );

    assign w_echo = w_echo_s[ch_q];

    // The rise cycle is itself one cycle of echo-high time, so it counts from zero.
    always_comb begin
        w_sub_base = (state_q == ST_MEASURE) ? sub_cnt_q : '0;
        w_cm_base  = (state_q == ST_MEASURE) ? cm_cnt_q  : '0;
        if (w_sub_base == c_sub_last) begin
            w_sub_next = '0;
            w_cm_next  = (w_cm_base == c_cm_max) ? w_cm_base : w_cm_base + 1'b1;
        end else begin
            w_sub_next = w_sub_base + 1'b1;
            w_cm_next  = w_cm_base;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        trig_cnt_d   = trig_cnt_q;
        period_cnt_d = (period_cnt_q == c_period_last) ? period_cnt_q : period_cnt_q + 1'b1;
        wait_cnt_d   = wait_cnt_q;
        sub_cnt_d    = sub_cnt_q;
        cm_cnt_d     = cm_cnt_q;
        dist_cm_d    = dist_cm_q;
        dist_ch_d    = dist_ch_q;
        timeout_d    = timeout_q;
        dist_valid_d = 1'b0;
        w_done       = 1'b0;
        w_fail       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                period_cnt_d = '0;
                if (enable) begin
                    state_d    = ST_TRIG;
                    trig_cnt_d = '0;
                end
            end
            ST_TRIG: begin
                if (trig_cnt_q == c_trig_last) begin
                    state_d    = ST_WAIT_RISE;
                    trig_cnt_d = '0;
                    wait_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (w_echo) begin
                    state_d    = ST_MEASURE;
                    wait_cnt_d = c_to_first;
                    sub_cnt_d  = w_sub_next;
                    cm_cnt_d   = w_cm_next;
                end else if (wait_cnt_q == c_to_last) begin
                    w_done = 1'b1;
                    w_fail = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!w_echo) begin
                    w_done = 1'b1;
                end else if (wait_cnt_q == c_to_last) begin
                    w_done = 1'b1;
                    w_fail = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    sub_cnt_d  = w_sub_next;
                    cm_cnt_d   = w_cm_next;
                end
            end
            ST_HOLDOFF: begin
                // period_cnt saturates, so a long measurement leaves after one cycle
                if (period_cnt_q == c_period_last) begin
                    ch_d         = (ch_q == c_ch_last) ? '0 : ch_q + 1'b1;
                    state_d      = enable ? ST_TRIG : ST_IDLE;
                    period_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_done) begin
            state_d      = ST_HOLDOFF;
            dist_valid_d = 1'b1;
            dist_ch_d    = ch_q;
            timeout_d    = w_fail;
            dist_cm_d    = w_fail ? c_cm_max : cm_cnt_q;
            wait_cnt_d   = '0;
            sub_cnt_d    = '0;
            cm_cnt_d     = '0;
        end

        trigger_d = (state_q == ST_TRIG) ? (N_CH'(1) << ch_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            trig_cnt_q   <= '0;
            period_cnt_q <= '0;
            wait_cnt_q   <= '0;
            sub_cnt_q    <= '0;
            cm_cnt_q     <= '0;
            trigger_q    <= '0;
            dist_cm_q    <= '0;
            dist_ch_q    <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            trig_cnt_q   <= trig_cnt_d;
            period_cnt_q <= period_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            cm_cnt_q     <= cm_cnt_d;
            trigger_q    <= trigger_d;
            dist_cm_q    <= dist_cm_d;
            dist_ch_q    <= dist_ch_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign trigger    = trigger_q;
    assign dist_cm    = dist_cm_q;
    assign dist_ch    = dist_ch_q;
    assign dist_valid = dist_valid_q;
    assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
// ============================================================================
// Module : tb_ultrasonic_ranger
// Brief  : Randomised echo responder with a distance/timeout reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ultrasonic_ranger;

    localparam int N_CH   = 2;
    localparam int TRIG   = 5;
    localparam int PERIOD = 200;
    localparam int TO     = 100;
    localparam int DIV    = 4;
    localparam int DW     = 5;
    localparam int CM_MAX = (1 << DW) - 1;

    typedef struct { int delay; int width; } plan_t;
    typedef struct { int cm; int ch; int to; bit nr; int rise; } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [1:0]      echo;
    logic [1:0]      trigger;
    logic [DW-1:0]   dist_cm;
    logic [0:0]      dist_ch;
    logic            dist_valid;
    logic            timeout;

    logic            en2;
    logic [1:0]      echo2;
    logic [1:0]      trigger2;
    logic [DW-1:0]   dist_cm2;
    logic [0:0]      dist_ch2;
    logic            dist_valid2;
    logic            timeout2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    int   meas_done   = 0;
    int   rise_cnt    = 0;
    int   overlap_cnt = 0;
    int   hold_err    = 0;
    bit   spacing_en  = 1'b0;
    bit   resp_abort  = 1'b0;

    ultrasonic_ranger #(
        .N_CH(N_CH), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(TO), .CM_DIV(DIV), .DIST_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trigger(trigger),
        .dist_cm(dist_cm), .dist_ch(dist_ch), .dist_valid(dist_valid), .timeout(timeout)
    );

    ultrasonic_ranger #(
        .N_CH(N_CH), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(300), .CM_DIV(DIV), .DIST_W(DW)
    ) dut_long (
        .clk(clk), .rst(rst), .enable(en2), .echo(echo2), .trigger(trigger2),
        .dist_cm(dist_cm2), .dist_ch(dist_ch2), .dist_valid(dist_valid2), .timeout(timeout2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sensor model: answer each trigger with an echo pulse and predict the report.
    initial begin : responder
        logic [1:0] prev;
        plan_t p;
        exp_t  e;
        int    ch;
        int    n;
        prev = '0;
        forever begin
            step();
            if (!rst && trigger != 2'b00 && prev == 2'b00) begin
                ch = trigger[1] ? 1 : 0;
                if (plan_q.size() != 0) begin
                    p = plan_q.pop_front();
                end else begin
                    p.delay = $urandom_range(0, 20);
                    p.width = ($urandom_range(0, 5) == 0) ? -1 : 4 * $urandom_range(0, 21) + 2;
                end
                e.ch   = ch;
                e.nr   = (p.width < 0);
                e.rise = cyc;
                if (p.width < 0 || p.width >= TO) begin
                    e.cm = CM_MAX;
                    e.to = 1;
                end else begin
                    e.cm = (p.width / DIV > CM_MAX) ? CM_MAX : p.width / DIV;
                    e.to = 0;
                end
                exp_q.push_back(e);
                n = 0;
                while (trigger != 2'b00 && n < 50 && !resp_abort) begin
                    step();
                    n++;
                end
                for (int k = 0; k < p.delay && !resp_abort; k++) step();
                if (p.width > 0 && !resp_abort) begin
                    echo[ch] = 1'b1;
                    for (int k = 0; k < p.width && !resp_abort; k++) step();
                    echo[ch] = 1'b0;
                end
            end
            prev = trigger;
        end
    end

    initial begin : monitor
        logic [1:0]    prev_trig;
        logic          prev_valid;
        logic [DW-1:0] h_cm;
        logic [0:0]    h_ch;
        logic          h_to;
        int            last_rise;
        int            last_ch;
        bit            last_valid;
        int            tw;
        int            mch;
        exp_t          e;
        prev_trig = '0; prev_valid = 1'b0; h_cm = '0; h_ch = '0; h_to = 1'b0;
        last_rise = 0; last_ch = 0; last_valid = 1'b0; tw = 0;
        forever begin
            step();
            if (trigger == 2'b11) overlap_cnt++;
            if (!rst && trigger != 2'b00 && prev_trig == 2'b00) begin
                rise_cnt++;
                mch = trigger[1] ? 1 : 0;
                if (spacing_en && last_valid) begin
                    check_eq("trig_spacing", cyc - last_rise, PERIOD);
                    check_eq("trig_ch_seq", mch, (last_ch + 1) % N_CH);
                end
                last_valid = spacing_en;
                last_rise  = cyc;
                last_ch    = mch;
                tw         = 0;
            end
            if (trigger != 2'b00) tw++;
            else if (prev_trig != 2'b00 && !rst) check_eq("trig_width", tw, TRIG);
            prev_trig = trigger;

            if (dist_valid) begin
                meas_done++;
                check_eq("valid_one_cycle", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    check_eq("valid_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("dist_cm", dist_cm, e.cm);
                    check_eq("dist_ch", dist_ch, e.ch);
                    check_eq("timeout", timeout, e.to);
                    if (e.nr)
                        check_eq("norise_latency_ok",
                                 (cyc - e.rise >= TO + TRIG - 2) && (cyc - e.rise <= TO + TRIG + 3), 1);
                end
            end else if (!rst && (dist_cm != h_cm || dist_ch != h_ch || timeout != h_to)) begin
                hold_err++;
            end
            prev_valid = dist_valid;
            h_cm = dist_cm; h_ch = dist_ch; h_to = timeout;
        end
    end

    initial begin : main
        int n;
        int base;
        int base_r;
        rst = 1'b1; enable = 1'b0; echo = '0; en2 = 1'b0; echo2 = '0;
        repeat (3) step();
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_dist_cm", dist_cm, 0);
        check_eq("rst_dist_ch", dist_ch, 0);
        check_eq("rst_valid", dist_valid, 0);
        check_eq("rst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b0;

        // Long-timeout instance: 130-cycle echo saturates the 5-bit distance.
        en2 = 1'b1;
        n = 0;
        while (trigger2[0] !== 1'b1 && n < 20) begin step(); n++; end
        check_eq("sat_trigger_seen", trigger2[0], 1);
        n = 0;
        while (trigger2 != 2'b00 && n < 20) begin step(); n++; end
        echo2[0] = 1'b1;
        repeat (130) step();
        echo2[0] = 1'b0;
        n = 0;
        while (!dist_valid2 && n < 20) begin step(); n++; end
        check_eq("sat_valid_seen", dist_valid2, 1);
        check_eq("sat_dist_cm", dist_cm2, CM_MAX);
        check_eq("sat_timeout", timeout2, 0);
        check_eq("sat_dist_ch", dist_ch2, 0);
        en2 = 1'b0;

        // Continuous scan: directed corner cases followed by random echoes.
        plan_q.push_back('{delay: 3, width: 42});
        plan_q.push_back('{delay: 0, width: -1});
        plan_q.push_back('{delay: 5, width: 150});
        plan_q.push_back('{delay: 0, width: 2});
        spacing_en = 1'b1;
        enable = 1'b1;
        n = 0;
        while (meas_done < 12 && n < 3000) begin step(); n++; end
        check_eq("scan_complete", meas_done >= 12, 1);

        // Enable dropped mid-measurement: result still arrives, then silence.
        spacing_en = 1'b0;
        plan_q.push_back('{delay: 2, width: 60});
        base = meas_done;
        n = 0;
        while (echo == 2'b00 && n < 400) begin step(); n++; end
        repeat (5) step();
        enable = 1'b0;
        n = 0;
        while (meas_done == base && n < 200) begin step(); n++; end
        check_eq("drop_en_reported", meas_done - base, 1);
        base_r = rise_cnt;
        repeat (450) step();
        check_eq("no_trig_after_drop", rise_cnt - base_r, 0);

        // Reset in the middle of a measurement.
        plan_q.push_back('{delay: 2, width: 80});
        enable = 1'b1;
        n = 0;
        while (echo == 2'b00 && n < 400) begin step(); n++; end
        repeat (10) step();
        #2;
        rst = 1'b1;
        resp_abort = 1'b1;
        #1;
        check_eq("midrst_trigger", trigger, 0);
        check_eq("midrst_valid", dist_valid, 0);
        check_eq("midrst_dist_cm", dist_cm, 0);
        enable = 1'b0;
        repeat (3) step();
        exp_q.delete();
        resp_abort = 1'b0;
        check_eq("midrst_dist_ch", dist_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        base = meas_done;
        n = 0;
        while (trigger == 2'b00 && n < 20) begin step(); n++; end
        check_eq("first_trig_not_early", n >= 2, 1);
        check_eq("restart_ch0", trigger, 2'b01);
        enable = 1'b0;
        n = 0;
        while (meas_done == base && n < 300) begin step(); n++; end
        check_eq("restart_reported", meas_done - base, 1);
        base_r = rise_cnt;
        repeat (300) step();
        check_eq("final_no_trig", rise_cnt - base_r, 0);
        check_eq("pending_results", exp_q.size(), 0);
        check_eq("trig_overlap", overlap_cnt, 0);
        check_eq("output_hold", hold_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
